// File: rtl/aes_pkg.sv
// ============================================================================
// Module  : aes_pkg
// Purpose : Shared AES widths, GF(2^8) xtime helper, inverse-mix FSM encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_COL_W   = 32;

    typedef enum logic [1:0] {
        IMC_IDLE = 2'd0,
        IMC_BUSY = 2'd1,
        IMC_DONE = 2'd2
    } imc_state_e;

    // Multiply by x in GF(2^8), reduction polynomial 0x11B
    function automatic logic [7:0] gf_mult2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/inv_mcol_column.sv
// ============================================================================
// Module  : inv_mcol_column
// Purpose : Combinational single-column AES InvMixColumns, matrix [0e 0b 0d 09].
// Revision: 1.0
// ============================================================================
`default_nettype none

module inv_mcol_column
    import aes_pkg::*;
(
    input  logic [AES_COL_W-1:0] i_col,
    output logic [AES_COL_W-1:0] o_col
);

    logic [7:0] w_a  [4];
    logic [7:0] w_m9 [4];
    logic [7:0] w_mb [4];
    logic [7:0] w_md [4];
    logic [7:0] w_me [4];

    // Byte 0 is the most significant byte of the column
    for (genvar k = 0; k < 4; k++) begin : g_byte
        logic [7:0] w_x2;
        logic [7:0] w_x4;
        logic [7:0] w_x8;

        assign w_a[k]  = i_col[31-8*k -: 8];
        assign w_x2    = gf_mult2(w_a[k]);
        assign w_x4    = gf_mult2(w_x2);
        assign w_x8    = gf_mult2(w_x4);
        assign w_m9[k] = w_x8 ^ w_a[k];
        assign w_mb[k] = w_x8 ^ w_x2 ^ w_a[k];
        assign w_md[k] = w_x8 ^ w_x4 ^ w_a[k];
        assign w_me[k] = w_x8 ^ w_x4 ^ w_x2;
    end

    assign o_col[31:24] = w_me[0] ^ w_mb[1] ^ w_md[2] ^ w_m9[3];
    assign o_col[23:16] = w_m9[0] ^ w_me[1] ^ w_mb[2] ^ w_md[3];
    assign o_col[15:8]  = w_md[0] ^ w_m9[1] ^ w_me[2] ^ w_mb[3];
    assign o_col[7:0]   = w_mb[0] ^ w_md[1] ^ w_m9[2] ^ w_me[3];

endmodule

`default_nettype wire

// File: rtl/inv_mcol_iter.sv
// ============================================================================
// Module  : inv_mcol_iter
// Purpose : Iterative InvMixColumns, one column per clock through a shared unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module inv_mcol_iter
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state
);

    localparam logic [1:0] ST_IDLE = IMC_IDLE;
    localparam logic [1:0] ST_BUSY = IMC_BUSY;
    localparam logic [1:0] ST_DONE = IMC_DONE;

    logic [1:0]             r_state;
    logic [1:0]             r_col;
    logic [AES_STATE_W-1:0] r_in_buf;
    logic [AES_STATE_W-1:0] r_out_state;
    logic [AES_COL_W-1:0]   w_col_in;
    logic [AES_COL_W-1:0]   w_col_out;

    always_comb begin
        w_col_in = r_in_buf[31:0];
        case (r_col)
            2'd0:    w_col_in = r_in_buf[31:0];
            2'd1:    w_col_in = r_in_buf[63:32];
            2'd2:    w_col_in = r_in_buf[95:64];
            default: w_col_in = r_in_buf[127:96];
        endcase
    end

    inv_mcol_column u_column (
        .i_col (w_col_in),
        .o_col (w_col_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_col       <= 2'd0;
            r_in_buf    <= '0;
            r_out_state <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_in_buf <= in_state;
                        r_col    <= 2'd0;
                        r_state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_out_state[{r_col, 5'd0} +: AES_COL_W] <= w_col_out;
                    r_col <= r_col + 2'd1;
                    if (r_col == 2'd3) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Ready is masked by rst so no block is offered acceptance during reset
    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign out_valid = (r_state == ST_DONE);
    assign out_state = r_out_state;

endmodule

`default_nettype wire
